niosii_system_sysid_checker: RTL and testbench

//  Avalon-MM master that reads the system-ID slave (ID word at offset 0x0,

---
 rtl/niosii_system_sysid_checker.sv | 189 ++++++++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_checker.sv
// System-ID checker: an Avalon-MM read master that fetches the sysid ID word
// (offset 0x0) and timestamp word (offset 0x4) after a start pulse. It compares
// both words against the values the image was built with and reports the result.
// Each read has its own cycle budget. A read that overruns the budget aborts the check.
module niosii_system_sysid_checker #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] SYSID_BASE  = {ADDR_W{1'b0}},
  parameter logic [31:0]       EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0]       EXPECTED_TS = 32'h0000_0000,
  parameter int                TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int                CNT_W    = (TIMEOUT < 32'sd2) ? 1 : $clog2(TIMEOUT + 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [ADDR_W-1:0] TS_ADDR  = SYSID_BASE + ADDR_W'(32'd4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_RSP_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_RSP_TS = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              rst_meta_r, rst_sync_n_r;
  logic              read_r, read_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              id_ok_r, id_ok_s;
  logic              ts_ok_r, ts_ok_s;
  logic              terr_r, terr_s;
  logic [31:0]       id_val_r, id_val_s;
  logic [31:0]       ts_val_r, ts_val_s;
  logic              accept_s, resp_s, is_ts_s;

  // The read is accepted on any cycle where it is presented without a stall.
  // A response counts in RSP_x, or in the accept cycle itself for a zero-latency slave.
  assign accept_s = read_r & ~avm_waitrequest;
  assign is_ts_s  = (state_r == ST_REQ_TS) || (state_r == ST_RSP_TS);
  assign resp_s   = avm_readdatavalid &
                    (accept_s || (state_r == ST_RSP_ID) || (state_r == ST_RSP_TS));

  // Reset synchronizer: assert immediately, release on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_r   <= 1'b0;
      rst_sync_n_r <= 1'b0;
    end else begin
      rst_meta_r   <= 1'b1;
      rst_sync_n_r <= rst_meta_r;
    end
  end

  // Next-state and next-output logic for the check sequence.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    read_s   = read_r;
    addr_s   = addr_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    id_ok_s  = id_ok_r;
    ts_ok_s  = ts_ok_r;
    terr_s   = terr_r;
    id_val_s = id_val_r;
    ts_val_s = ts_val_r;
    case (state_r)
      ST_IDLE: begin
        // busy stays high through the done cycle, so a start there is ignored
        busy_s = 1'b0;
        if (start && !busy_r) begin
          state_s  = ST_REQ_ID;
          read_s   = 1'b1;
          addr_s   = SYSID_BASE;
          cnt_s    = {CNT_W{1'b0}};
          busy_s   = 1'b1;
          id_ok_s  = 1'b0;
          ts_ok_s  = 1'b0;
          terr_s   = 1'b0;
          id_val_s = 32'h0000_0000;
          ts_val_s = 32'h0000_0000;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ_ID, ST_RSP_ID, ST_REQ_TS, ST_RSP_TS: begin
        if (resp_s) begin
          // a response arriving on the last budget cycle still counts
          cnt_s = {CNT_W{1'b0}};
          if (is_ts_s) begin
            ts_val_s = avm_readdata;
            read_s   = 1'b0;
            state_s  = ST_FIN;
          end else begin
            id_val_s = avm_readdata;
            read_s   = 1'b1;
            addr_s   = TS_ADDR;
            state_s  = ST_REQ_TS;
          end
        end else if (cnt_r == CNT_LAST) begin
          terr_s  = 1'b1;
          read_s  = 1'b0;
          state_s = ST_FIN;
        end else begin
          cnt_s = cnt_r + 1'b1;
          if (accept_s) begin
            read_s  = 1'b0;
            state_s = is_ts_s ? ST_RSP_TS : ST_RSP_ID;
          end else begin
            read_s = read_r;
          end
        end
      end
      ST_FIN: begin
        id_ok_s = ~terr_r & (id_val_r == EXPECTED_ID);
        ts_ok_s = ~terr_r & (ts_val_r == EXPECTED_TS);
        done_s  = 1'b1;
        read_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        read_s  = 1'b0;
        busy_s  = 1'b0;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge rst_sync_n_r) begin
    if (!rst_sync_n_r) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      read_r   <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      id_ok_r  <= 1'b0;
      ts_ok_r  <= 1'b0;
      terr_r   <= 1'b0;
      id_val_r <= 32'h0000_0000;
      ts_val_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      read_r   <= read_s;
      addr_r   <= addr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      id_ok_r  <= id_ok_s;
      ts_ok_r  <= ts_ok_s;
      terr_r   <= terr_s;
      id_val_r <= id_val_s;
      ts_val_r <= ts_val_s;
    end
  end

  assign avm_address = addr_r;
  assign avm_read    = read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign timeout_err = terr_r;
  assign id_value    = id_val_r;
  assign ts_value    = ts_val_r;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Self-checking bench for niosii_system_sysid_checker. A behavioural sysid slave
// is driven cycle by cycle. Expected results come from per-read durations and
// the check rules.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] BASE   = 32'h0002_1040;
  localparam logic [31:0] EXP_ID = 32'h58B5_2E69;
  localparam logic [31:0] EXP_TS = 32'h5F3A_0C17;
  localparam int          TMO    = 8;

  logic        clock, reset_n, start;
  logic [31:0] avm_address, avm_readdata, id_value, ts_value;
  logic        avm_read, avm_waitrequest, avm_readdatavalid;
  logic        busy, done, id_ok, ts_ok, timeout_err;

  niosii_system_sysid_checker #(
    .ADDR_W(32), .SYSID_BASE(BASE), .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // slave configuration per read (index 0 = ID, 1 = TS)
  int          w_cfg [2];
  int          l_cfg [2];
  bit          hang_cfg [2];
  logic [31:0] data_cfg [2];

  // observations gathered by the driver
  int          acc_cnt, stab_err, done_cnt, done_cyc, busy_err;
  bit          aborted;
  logic [31:0] addr_seen [2];
  logic [31:0] id_cyc1;

  // expected results
  int          e_done, e_acc;
  logic [31:0] e_id, e_ts;
  logic [2:0]  e_flags;

  task automatic set_cfg(input int w0, input int l0, input bit h0, input logic [31:0] d0,
                         input int w1, input int l1, input bit h1, input logic [31:0] d1);
    w_cfg[0] = w0; l_cfg[0] = l0; hang_cfg[0] = h0; data_cfg[0] = d0;
    w_cfg[1] = w1; l_cfg[1] = l1; hang_cfg[1] = h1; data_cfg[1] = d1;
  endtask

  function automatic bit read_overruns(input int i);
    return hang_cfg[i] || (w_cfg[i] + 1 + l_cfg[i] > TMO);
  endfunction

  function automatic int read_cycles(input int i);
    return read_overruns(i) ? TMO : w_cfg[i] + 1 + l_cfg[i];
  endfunction

  // Reference model: a read lasts stall+1+latency cycles unless it overruns the budget.
  task automatic predict();
    bit to_id, to_ts, terr;
    to_id   = read_overruns(0);
    to_ts   = !to_id && read_overruns(1);
    terr    = to_id || to_ts;
    e_done  = read_cycles(0) + (to_id ? 0 : read_cycles(1)) + 2;
    e_acc   = to_id ? 1 : 2;
    e_id    = to_id ? 32'h0 : data_cfg[0];
    e_ts    = terr ? 32'h0 : data_cfg[1];
    e_flags = {!terr && (e_id == EXP_ID), !terr && (e_ts == EXP_TS), terr};
  endtask

  // Pulse start, then play the slave each cycle until done has been seen plus two cycles.
  task automatic drive_check(input bit spam_start, input bit abort_rsp_ts);
    int stall_left, resp_left, idx;
    bit req_open, resp_open, finished;
    logic [31:0] req_addr;
    stall_left = 0; resp_left = 0; idx = 0; req_open = 1'b0; resp_open = 1'b0;
    finished = 1'b0; req_addr = 32'h0;
    acc_cnt = 0; stab_err = 0; done_cnt = 0; done_cyc = -1; busy_err = 0; aborted = 1'b0;
    addr_seen[0] = 32'hFFFF_FFFF; addr_seen[1] = 32'hFFFF_FFFF; id_cyc1 = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b1;
    for (int cyc = 1; cyc <= 150 && !finished; cyc++) begin
      @(negedge clock);
      start = spam_start && (busy === 1'b1) && ($urandom_range(1, 0) == 1);
      if (abort_rsp_ts && acc_cnt == 2 && resp_open) begin
        reset_n = 1'b0;
        avm_readdatavalid = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (cyc == 1) id_cyc1 = id_value;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((done_cyc < 0 || cyc == done_cyc) != (busy === 1'b1)) busy_err++;
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = $urandom();
      if (resp_open) begin
        if (resp_left == 1) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = data_cfg[idx];
          resp_open         = 1'b0;
        end else if (resp_left > 1) begin
          resp_left--;
        end
      end
      if (avm_read === 1'b1) begin
        if (!req_open) begin
          req_open = 1'b1;
          idx = (acc_cnt > 1) ? 1 : acc_cnt;
          stall_left = w_cfg[idx];
          req_addr = avm_address;
          addr_seen[idx] = avm_address;
        end else if (avm_address !== req_addr) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          acc_cnt++;
          req_open = 1'b0;
          if (hang_cfg[idx]) begin
            resp_open = 1'b1; resp_left = 0;
          end else if (l_cfg[idx] == 0) begin
            avm_readdatavalid = 1'b1; avm_readdata = data_cfg[idx];
          end else begin
            resp_open = 1'b1; resp_left = l_cfg[idx];
          end
        end
      end else begin
        avm_waitrequest = ($urandom_range(1, 0) == 1);
        if (req_open) stab_err++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
    end
    start = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; avm_waitrequest = 1'b0;
    avm_readdata = 32'h0; avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clock);
    if ({busy, done, avm_read, id_ok, ts_ok, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, avm_read, id_ok, ts_ok, timeout_err});
    end
    checks++;
    if (avm_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", avm_address); end
    checks++;
    if ({id_value, ts_value} !== 64'h0) begin errors++; $display("FAIL reset_values: got %h %h want 0 0", id_value, ts_value); end
    checks++;
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_zero_wait();
    set_cfg(0, 0, 1'b0, EXP_ID, 0, 0, 1'b0, EXP_TS);
    predict();
    drive_check(1'b0, 1'b0);
    if (done_cyc !== 4) begin errors++; $display("FAIL zw_latency: got %0d want 4", done_cyc); end
    checks++;
    if (addr_seen[0] !== BASE) begin errors++; $display("FAIL zw_addr_id: got %h want %h", addr_seen[0], BASE); end
    checks++;
    if (addr_seen[1] !== BASE + 32'd4) begin errors++; $display("FAIL zw_addr_ts: got %h want %h", addr_seen[1], BASE + 32'd4); end
    checks++;
    if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin errors++; $display("FAIL zw_flags: got %b want 110", {id_ok, ts_ok, timeout_err}); end
    checks++;
    if (done_cnt !== 1 || acc_cnt !== 2) begin errors++; $display("FAIL zw_counts: got done=%0d acc=%0d want 1 2", done_cnt, acc_cnt); end
    checks++;
    if (busy_err !== 0) begin errors++; $display("FAIL zw_busy: got %0d bad cycles want 0", busy_err); end
    checks++;
  endtask

  task automatic test_id_mismatch();
    set_cfg(0, 0, 1'b0, 32'h5896_3B6A, 0, 0, 1'b0, EXP_TS);
    drive_check(1'b0, 1'b0);
    if ({id_ok, ts_ok, timeout_err} !== 3'b010) begin errors++; $display("FAIL mm_flags: got %b want 010", {id_ok, ts_ok, timeout_err}); end
    checks++;
    if (id_value !== 32'h5896_3B6A) begin errors++; $display("FAIL mm_id_value: got %h want 58963b6a", id_value); end
    checks++;
    if (ts_value !== EXP_TS) begin errors++; $display("FAIL mm_ts_value: got %h want %h", ts_value, EXP_TS); end
    checks++;
  endtask

  task automatic test_stall();
    set_cfg(3, 2, 1'b0, EXP_ID, 3, 2, 1'b0, EXP_TS);
    predict();
    drive_check(1'b0, 1'b0);
    if (stab_err !== 0) begin errors++; $display("FAIL st_stable: got %0d glitches want 0", stab_err); end
    checks++;
    if (acc_cnt !== 2) begin errors++; $display("FAIL st_accepts: got %0d want 2", acc_cnt); end
    checks++;
    if (done_cyc !== e_done) begin errors++; $display("FAIL st_latency: got %0d want %0d", done_cyc, e_done); end
    checks++;
    if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin errors++; $display("FAIL st_flags: got %b want 110", {id_ok, ts_ok, timeout_err}); end
    checks++;
    if (busy_err !== 0) begin errors++; $display("FAIL st_busy: got %0d bad cycles want 0", busy_err); end
    checks++;
  endtask

  task automatic test_timeout();
    set_cfg(0, 0, 1'b1, EXP_ID, 0, 0, 1'b0, EXP_TS);
    drive_check(1'b0, 1'b0);
    if ({id_ok, ts_ok, timeout_err} !== 3'b001) begin errors++; $display("FAIL to_flags: got %b want 001", {id_ok, ts_ok, timeout_err}); end
    checks++;
    if (acc_cnt !== 1) begin errors++; $display("FAIL to_accepts: got %0d want 1", acc_cnt); end
    checks++;
    if (done_cyc !== TMO + 2) begin errors++; $display("FAIL to_latency: got %0d want %0d", done_cyc, TMO + 2); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL to_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (id_value !== 32'h0) begin errors++; $display("FAIL to_id_value: got %h want 0", id_value); end
    checks++;
  endtask

  task automatic test_timeout_boundary();
    // a read that completes on exactly the last budget cycle is good
    set_cfg(3, TMO - 4, 1'b0, EXP_ID, 0, 0, 1'b0, EXP_TS);
    drive_check(1'b0, 1'b0);
    if ({id_ok, ts_ok, timeout_err} !== 3'b110 || done_cyc !== TMO + 3) begin
      errors++; $display("FAIL bd_at_limit: got %b/%0d want 110/%0d", {id_ok, ts_ok, timeout_err}, done_cyc, TMO + 3);
    end
    checks++;
    // one cycle longer on the TS read overruns
    set_cfg(0, 0, 1'b0, EXP_ID, 3, TMO - 3, 1'b0, EXP_TS);
    drive_check(1'b0, 1'b0);
    if ({id_ok, ts_ok, timeout_err} !== 3'b001 || done_cyc !== TMO + 3) begin
      errors++; $display("FAIL bd_over_limit: got %b/%0d want 001/%0d", {id_ok, ts_ok, timeout_err}, done_cyc, TMO + 3);
    end
    checks++;
    if (id_value !== EXP_ID || ts_value !== 32'h0) begin errors++; $display("FAIL bd_values: got %h %h want %h 0", id_value, ts_value, EXP_ID); end
    checks++;
  endtask

  task automatic test_start_while_busy();
    set_cfg(2, 3, 1'b0, EXP_ID, 1, 4, 1'b0, 32'h1234_5678);
    drive_check(1'b1, 1'b0);
    if (done_cnt !== 1) begin errors++; $display("FAIL sb_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (acc_cnt !== 2) begin errors++; $display("FAIL sb_accepts: got %0d want 2", acc_cnt); end
    checks++;
    repeat (3) @(negedge clock);
    if (busy !== 1'b0 || avm_read !== 1'b0) begin errors++; $display("FAIL sb_idle: got busy=%b read=%b want 0 0", busy, avm_read); end
    checks++;
  endtask

  task automatic test_reset_mid_read();
    int late_done;
    set_cfg(0, 0, 1'b0, EXP_ID, 0, 3, 1'b0, EXP_TS);
    drive_check(1'b0, 1'b1);
    if (aborted !== 1'b1) begin errors++; $display("FAIL rm_reached_rsp_ts: got %b want 1", aborted); end
    checks++;
    #1;
    if ({busy, done, avm_read, id_ok, ts_ok, timeout_err} !== 6'b0 || id_value !== 32'h0) begin
      errors++; $display("FAIL rm_async_clear: got %b id=%h want 000000 0", {busy, done, avm_read, id_ok, ts_ok, timeout_err}, id_value);
    end
    checks++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) late_done++;
      avm_readdatavalid = (i >= 1 && i <= 4);
      avm_readdata = EXP_TS;
    end
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    if (late_done !== 0) begin errors++; $display("FAIL rm_late_resp: got %0d busy/done cycles want 0", late_done); end
    checks++;
    if ({id_value, ts_value} !== 64'h0 || {id_ok, ts_ok} !== 2'b00) begin
      errors++; $display("FAIL rm_values: got %h %h %b want 0 0 00", id_value, ts_value, {id_ok, ts_ok});
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      set_cfg($urandom_range(3, 0), $urandom_range(5, 0), ($urandom_range(5, 0) == 0),
              ($urandom_range(1, 0) == 1) ? EXP_ID : $urandom(),
              $urandom_range(3, 0), $urandom_range(5, 0), ($urandom_range(5, 0) == 0),
              ($urandom_range(1, 0) == 1) ? EXP_TS : $urandom());
      predict();
      drive_check(($urandom_range(1, 0) == 1), 1'b0);
      if (done_cyc !== e_done || done_cnt !== 1) begin
        errors++; $display("FAIL rnd%0d_done: got cyc=%0d n=%0d want cyc=%0d n=1", n, done_cyc, done_cnt, e_done);
      end
      checks++;
      if (acc_cnt !== e_acc || stab_err !== 0 || busy_err !== 0) begin
        errors++; $display("FAIL rnd%0d_bus: got acc=%0d stab=%0d busy=%0d want %0d 0 0", n, acc_cnt, stab_err, busy_err, e_acc);
      end
      checks++;
      if (id_value !== e_id || ts_value !== e_ts) begin
        errors++; $display("FAIL rnd%0d_values: got %h %h want %h %h", n, id_value, ts_value, e_id, e_ts);
      end
      checks++;
      if ({id_ok, ts_ok, timeout_err} !== e_flags) begin
        errors++; $display("FAIL rnd%0d_flags: got %b want %b", n, {id_ok, ts_ok, timeout_err}, e_flags);
      end
      checks++;
      if (id_cyc1 !== 32'h0 || addr_seen[0] !== BASE) begin
        errors++; $display("FAIL rnd%0d_clear_addr: got %h %h want 0 %h", n, id_cyc1, addr_seen[0], BASE);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_id_mismatch();
    test_stall();
    test_timeout();
    test_timeout_boundary();
    test_start_while_busy();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
